// File: rtl/vram_access_sched.sv
// vram_access_sched: single-port VRAM arbiter, display reads over FIFO-buffered host writes with a starvation slot.
// Optional VRAM_AUTOINC_EN replaces host_wr_addr_i with an auto-incrementing pointer (loadable via host_ptr_load_i).
module vram_access_sched #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT = 64,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = PW + 1,
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_wr_valid_i,
  output logic          host_wr_ready_o,
  input  logic [AW-1:0] host_wr_addr_i,
  input  logic [DW-1:0] host_wr_data_i,
`ifdef VRAM_AUTOINC_EN
  input  logic          host_ptr_load_i,
`endif
  input  logic          disp_rd_req_i,
  input  logic [AW-1:0] disp_rd_addr_i,
  output logic          disp_rd_grant_o,
  output logic          disp_rd_valid_o,
  output logic [DW-1:0] disp_rd_data_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic          ram_we_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic [LW-1:0] fifo_level_o,
  output logic          overflow_o
);
  typedef enum logic [1:0] {IDLE, DISP, HOST} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d, wr_addr;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          ram_we_q, rd_valid_q, ovf_q;
  logic          ne, push, pop, force_slot, grant;
`ifdef VRAM_AUTOINC_EN
  logic [AW-1:0] ptr_q;
  assign wr_addr = host_ptr_load_i ? host_wr_addr_i : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= push ? wr_addr + AW'(1) : (host_ptr_load_i ? host_wr_addr_i : ptr_q);
`else
  assign wr_addr = host_wr_addr_i;
`endif
  assign ne              = lvl_q != '0;
  assign host_wr_ready_o = lvl_q != LW'(FIFO_DEPTH);
  assign push            = host_wr_valid_i & host_wr_ready_o;
  // a forced slot always pops, so the starve counter can never pass STARVE_LIMIT-1
  assign force_slot      = ne & (starve_q >= SW'(STARVE_LIMIT - 1));
  assign grant           = disp_rd_req_i & ~force_slot;
  assign pop             = ne & (~disp_rd_req_i | force_slot);
  always_comb begin
    state_d     = grant ? DISP : (pop ? HOST : IDLE);
    ram_addr_d  = grant ? disp_rd_addr_i : (pop ? fifo_addr_q[rp_q] : ram_addr_q);
    ram_wdata_d = pop ? fifo_data_q[rp_q] : ram_wdata_q;
    lvl_d       = lvl_q + LW'(push) - LW'(pop);
    starve_d    = (pop | ~ne) ? '0 : starve_q + SW'(1);
  end
  always_ff @(posedge clk)
    if (push) begin
      fifo_addr_q[wp_q] <= wr_addr;
      fifo_data_q[wp_q] <= host_wr_data_i;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      wp_q        <= '0;
      rp_q        <= '0;
      lvl_q       <= '0;
      starve_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= pop;
      rd_valid_q  <= state_q == DISP;
      wp_q        <= wp_q + PW'(push);
      rp_q        <= rp_q + PW'(pop);
      lvl_q       <= lvl_d;
      starve_q    <= starve_d;
      ovf_q       <= ovf_q | (host_wr_valid_i & ~host_wr_ready_o);
    end
  assign disp_rd_grant_o = grant;
  assign disp_rd_valid_o = rd_valid_q;
  assign disp_rd_data_o  = ram_rdata_i;
  assign ram_addr_o      = ram_addr_q;
  assign ram_wdata_o     = ram_wdata_q;
  assign ram_we_o        = ram_we_q;
  assign fifo_level_o    = lvl_q;
  assign overflow_o      = ovf_q;
endmodule

// File: tb/tb_vram_access_sched.sv
// tb_vram_access_sched: scoreboard bench; stimulus queues expected VRAM writes and read data, a monitor pops and compares.
module tb_vram_access_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_wr_valid = 1'b0;
  logic        host_wr_ready;
  logic [15:0] host_wr_addr = '0;
  logic [7:0]  host_wr_data = '0;
`ifdef VRAM_AUTOINC_EN
  logic        host_ptr_load = 1'b0;
`endif
  logic        disp_rd_req = 1'b0;
  logic [15:0] disp_rd_addr = '0;
  logic        disp_rd_grant, disp_rd_valid, ram_we, overflow;
  logic [7:0]  disp_rd_data, ram_wdata, ram_rdata;
  logic [15:0] ram_addr;
  logic [2:0]  fifo_level;
  int          checks = 0, failures = 0, cyc = 0;
  logic [7:0]  vram [65536];
  typedef struct {logic [15:0] a; logic [7:0] d; int c;} wr_t;
  typedef struct {logic [7:0] d; int c;} rd_t;
  wr_t wq[$];
  rd_t rq[$];
  wr_t we_e;
  rd_t re_e;

  vram_access_sched dut (
    .clk(clk), .rst_n(rst_n),
    .host_wr_valid_i(host_wr_valid), .host_wr_ready_o(host_wr_ready),
    .host_wr_addr_i(host_wr_addr), .host_wr_data_i(host_wr_data),
`ifdef VRAM_AUTOINC_EN
    .host_ptr_load_i(host_ptr_load),
`endif
    .disp_rd_req_i(disp_rd_req), .disp_rd_addr_i(disp_rd_addr),
    .disp_rd_grant_o(disp_rd_grant), .disp_rd_valid_o(disp_rd_valid), .disp_rd_data_o(disp_rd_data),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we), .ram_rdata_i(ram_rdata),
    .fifo_level_o(fifo_level), .overflow_o(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  initial for (int i = 0; i < 65536; i++) vram[i] = f(16'(i));
  always @(posedge clk) begin
    if (ram_we) vram[ram_addr] <= ram_wdata;
    ram_rdata <= vram[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (rst_n) begin
    if (ram_we) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h/%0h expected=none", ram_addr, ram_wdata);
      end else begin
        we_e = wq.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(we_e.a));
        chk("wr_data", 32'(ram_wdata), 32'(we_e.d));
        if (we_e.c >= 0) chk("wr_cycle", cyc, we_e.c);
      end
    end
    if (disp_rd_valid) begin
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read actual=%0h expected=none", disp_rd_data);
      end else begin
        re_e = rq.pop_front();
        chk("rd_data", 32'(disp_rd_data), 32'(re_e.d));
        chk("rd_cycle", cyc, re_e.c);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int p, a;
    int zeros;
    #3;
    chk("rst_ready", 32'(host_wr_ready), 1);
    chk("rst_valid", 32'(disp_rd_valid), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    repeat (2) step();
    rst_n = 1'b1;
    // T2 display-only stream
    for (int i = 0; i < 8; i++) begin
      step();
      disp_rd_req = 1'b1;
      disp_rd_addr = 16'(i);
      @(negedge clk);
      chk("t2_grant", 32'(disp_rd_grant), 1);
      rq.push_back('{f(16'(i)), cyc + 2});
    end
    step();
    disp_rd_req = 1'b0;
    repeat (4) step();
    chk("t2_rq_drained", rq.size(), 0);
    // T3 blanking writes
    for (int i = 0; i < 3; i++) begin
      step();
      host_wr_valid = 1'b1;
      host_wr_addr = 16'h0100 + 16'(i);
      host_wr_data = (i == 0) ? 8'hA5 : (i == 1) ? 8'h5A : 8'hFF;
      wq.push_back('{host_wr_addr, host_wr_data, cyc + 2});
      @(negedge clk);
      chk("t3_level", 32'(fifo_level), (i == 0) ? 0 : 1);
    end
    step();
    host_wr_valid = 1'b0;
    repeat (4) step();
    chk("t3_level_end", 32'(fifo_level), 0);
    chk("t3_wq_drained", wq.size(), 0);
    // T1 reset mid-burst: display busy, FIFO overfilled, then async reset
    for (int j = 0; j < 6; j++) begin
      step();
      disp_rd_req = 1'b1;
      disp_rd_addr = 16'h0040 + 16'(j);
      host_wr_valid = j < 5;
      host_wr_addr = 16'h0500 + 16'(j);
      host_wr_data = 8'(j);
      rq.push_back('{f(disp_rd_addr), cyc + 2});
      @(negedge clk);
      if (j == 4) chk("t1_ready_full", 32'(host_wr_ready), 0);
      if (j == 4) chk("t1_level_full", 32'(fifo_level), 4);
      if (j == 5) chk("t1_overflow", 32'(overflow), 1);
    end
    step();
    #2;
    rst_n = 1'b0;
    host_wr_valid = 1'b0;
    disp_rd_req = 1'b0;
    #1;
    wq.delete();
    rq.delete();
    chk("t1_rst_ready", 32'(host_wr_ready), 1);
    chk("t1_rst_valid", 32'(disp_rd_valid), 0);
    chk("t1_rst_we", 32'(ram_we), 0);
    chk("t1_rst_addr", 32'(ram_addr), 0);
    chk("t1_rst_wdata", 32'(ram_wdata), 0);
    chk("t1_rst_level", 32'(fifo_level), 0);
    chk("t1_rst_overflow", 32'(overflow), 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("t1_post_level", 32'(fifo_level), 0);
    chk("t1_post_we", 32'(ram_we), 0);
    chk("t1_post_valid", 32'(disp_rd_valid), 0);
    // T4 starvation slot
    a = 0;
    zeros = 0;
    p = 0;
    for (int j = 0; j <= 70; j++) begin
      step();
      if (j == 0) begin
        p = cyc;
        wq.push_back('{16'h0200, 8'h77, p + 65});
      end
      host_wr_valid = j == 0;
      host_wr_addr = 16'h0200;
      host_wr_data = 8'h77;
      disp_rd_req = 1'b1;
      disp_rd_addr = 16'h0010 + 16'(a);
      @(negedge clk);
      if (!disp_rd_grant) zeros++;
      if (j == 64) chk("t4_grant_stolen", 32'(disp_rd_grant), 0);
      if (j == 65) chk("t4_grant_resume", 32'(disp_rd_grant), 1);
      if (j != 64) begin
        rq.push_back('{f(disp_rd_addr), cyc + 2});
        a++;
      end
    end
    chk("t4_zero_grants", zeros, 1);
    step();
    disp_rd_req = 1'b0;
    repeat (4) step();
    chk("t4_wq_drained", wq.size(), 0);
    chk("t4_rq_drained", rq.size(), 0);
    // T5 full/overflow with display busy, then drain
    for (int j = 0; j < 20; j++) begin
      step();
      host_wr_valid = j < 5;
      host_wr_addr = 16'h0300 + 16'(j);
      host_wr_data = 8'hC0 + 8'(j);
      if (j < 4) wq.push_back('{host_wr_addr, host_wr_data, -1});
      disp_rd_req = 1'b1;
      disp_rd_addr = 16'h0020 + 16'(j);
      rq.push_back('{f(disp_rd_addr), cyc + 2});
      @(negedge clk);
      if (j == 3) chk("t5_ready_before", 32'(host_wr_ready), 1);
      if (j == 4) chk("t5_ready_full", 32'(host_wr_ready), 0);
      if (j == 4) chk("t5_overflow_before", 32'(overflow), 0);
      if (j == 5) chk("t5_overflow", 32'(overflow), 1);
      if (j == 10) chk("t5_level_held", 32'(fifo_level), 4);
    end
    step();
    disp_rd_req = 1'b0;
    repeat (8) step();
    chk("t5_level_end", 32'(fifo_level), 0);
    chk("t5_ready_end", 32'(host_wr_ready), 1);
    chk("t5_overflow_sticky", 32'(overflow), 1);
`ifdef VRAM_AUTOINC_EN
    // T6 auto-increment with wrap; host_wr_addr ignored except on load
    step();
    host_ptr_load = 1'b1;
    host_wr_valid = 1'b1;
    host_wr_addr = 16'hFFFE;
    host_wr_data = 8'h11;
    wq.push_back('{16'hFFFE, 8'h11, cyc + 2});
    step();
    host_ptr_load = 1'b0;
    host_wr_addr = 16'h1234;
    host_wr_data = 8'h22;
    wq.push_back('{16'hFFFF, 8'h22, cyc + 2});
    step();
    host_wr_data = 8'h33;
    wq.push_back('{16'h0000, 8'h33, cyc + 2});
    step();
    host_wr_valid = 1'b0;
    repeat (4) step();
`endif
    repeat (3) step();
    chk("end_wq_empty", wq.size(), 0);
    chk("end_rq_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
